// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the program-counter fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;
    localparam int PC_W = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W = 16;
    localparam logic [PC_W-1:0] PC_RESET = '0;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-address select (sequential, absolute or relative branch)
module pc_next_calc #(
    parameter int PC_W = fetch_pkg::PC_W
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_branch_en,
    input  logic            i_branch_abs,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_next_pc
);
    // Relative offsets are two's complement, so a plain PC_W-bit add wraps correctly
    assign o_next_pc = !i_branch_en ? i_pc + PC_W'(1) :
                       i_branch_abs ? i_target : i_pc + i_target;
endmodule

// File: rtl/prog_ctr_fetch.sv
// prog_ctr_fetch: PC register, start/halt FSM and saturating RUN cycle counter
module prog_ctr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W = fetch_pkg::PC_W,
    parameter int CNT_W = fetch_pkg::CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [PC_W-1:0]  i_start_addr,
    input  logic             i_halt,
    input  logic             i_stall,
    input  logic             i_branch_en,
    input  logic             i_branch_abs,
    input  logic [PC_W-1:0]  i_target,
    output logic [PC_W-1:0]  o_prog_ctr,
    output logic             o_running,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cycle_cnt
);
    fetch_state_t     r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  w_next_pc;
    logic [CNT_W-1:0] w_cnt_inc;

    pc_next_calc #(.PC_W(PC_W)) u_pc_next (
        .i_pc        (r_pc),
        .i_branch_en (i_branch_en),
        .i_branch_abs(i_branch_abs),
        .i_target    (i_target),
        .o_next_pc   (w_next_pc)
    );

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_pc    <= PC_W'(PC_RESET);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_cnt <= w_cnt_inc;
                    if (i_halt)
                        r_state <= DONE;
                    else if (!i_stall)
                        r_pc <= w_next_pc;
                end
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state <= RUN;
                        r_pc    <= i_start_addr;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_prog_ctr  = r_pc;
    assign o_running   = (r_state == RUN);
    assign o_done      = (r_state == DONE);
    assign o_cycle_cnt = r_cnt;
endmodule
